// File: rtl/mem_bus.sv
// Memory and I/O controller behind the multicycle core: block RAM, LED/UART/cycle-counter
// registers, fixed-latency reads and a sticky bus-error flag for bad accesses.
module mem_bus #(
    parameter int RAM_WORDS = 1024,
    parameter int UART_DIV  = 104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [15:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [7:0]  leds,
    output logic        uart_tx,
    output logic        err
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          DW        = $clog2(UART_DIV);
    localparam logic [16:0] RAM_BYTES = 17'(RAM_WORDS * 4);
    localparam logic [15:0] LED_ADDR  = 16'hF000;
    localparam logic [15:0] UART_ADDR = 16'hF004;
    localparam logic [15:0] CNT_ADDR  = 16'hF008;
    localparam logic [DW-1:0] DIV_LAST = DW'(UART_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} rd_state_t;

    rd_state_t   state_reg;
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_q_reg;
    logic        sel_ram_reg;
    logic [31:0] mmio_snap_reg;
    logic [31:0] rd_data_reg;
    logic        rd_valid_reg;
    logic [7:0]  leds_reg;
    logic        err_reg;
    logic [31:0] cnt_reg;
    logic        uart_busy_reg;
    logic        uart_tx_reg;
    logic [9:0]  uart_shift_reg;
    logic [3:0]  uart_bit_reg;
    logic [DW-1:0] uart_div_reg;

    // Decode ignores addr[1:0]; misalignment only raises err.
    logic        rd_ram, rd_led, rd_uart, rd_cnt, rd_bad;
    logic        wr_ram, wr_led, wr_uart, wr_bad;
    logic        rd_accept;
    logic [31:0] mmio_val;

    assign rd_ram  = ({1'b0, rd_addr[15:2], 2'b00} < RAM_BYTES);
    assign rd_led  = (rd_addr[15:2] == LED_ADDR[15:2]);
    assign rd_uart = (rd_addr[15:2] == UART_ADDR[15:2]);
    assign rd_cnt  = (rd_addr[15:2] == CNT_ADDR[15:2]);
    assign rd_bad  = (rd_addr[1:0] != 2'b00) || !(rd_ram || rd_led || rd_uart || rd_cnt);

    assign wr_ram  = ({1'b0, wr_addr[15:2], 2'b00} < RAM_BYTES);
    assign wr_led  = (wr_addr[15:2] == LED_ADDR[15:2]);
    assign wr_uart = (wr_addr[15:2] == UART_ADDR[15:2]);
    assign wr_bad  = (wr_addr[1:0] != 2'b00) || !(wr_ram || wr_led || wr_uart);

    assign rd_accept = (state_reg == S_IDLE) && rd_en && !rst;

    assign mmio_val = rd_led  ? {24'b0, leds_reg} :
                      rd_uart ? {31'b0, uart_busy_reg} :
                      rd_cnt  ? cnt_reg : 32'b0;

    // Read-first block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ram && !rst)
            ram[wr_addr[AW+1:2]] <= wr_data;
        if (rd_accept)
            ram_q_reg <= ram[rd_addr[AW+1:2]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            sel_ram_reg    <= 1'b0;
            mmio_snap_reg  <= '0;
            rd_valid_reg   <= 1'b0;
            rd_data_reg    <= '0;
            leds_reg       <= '0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            uart_busy_reg  <= 1'b0;
            uart_tx_reg    <= 1'b1;
            uart_shift_reg <= '1;
            uart_bit_reg   <= '0;
            uart_div_reg   <= '0;
        end else begin
            cnt_reg      <= cnt_reg + 32'd1;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;

            case (state_reg)
                S_IDLE: begin
                    if (rd_en) begin
                        state_reg     <= S_WAIT;
                        sel_ram_reg   <= rd_ram;
                        mmio_snap_reg <= mmio_val;
                        if (rd_bad)
                            err_reg <= 1'b1;
                    end
                end
                S_WAIT: begin
                    state_reg    <= S_RESP;
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= sel_ram_reg ? ram_q_reg : mmio_snap_reg;
                end
                S_RESP: state_reg <= S_GAP;
                S_GAP: begin
                    // A request still held from the last transfer must drop before re-arming.
                    if (!rd_en)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase

            if (wr_en) begin
                if (wr_bad)
                    err_reg <= 1'b1;
                if (wr_led)
                    leds_reg <= wr_data[7:0];
            end

            // Frame shifter: {stop, data[7:0], start}, LSB leaves first.
            if (uart_busy_reg) begin
                if (uart_div_reg == DIV_LAST) begin
                    uart_div_reg <= '0;
                    if (uart_bit_reg == 4'd9) begin
                        uart_busy_reg <= 1'b0;
                        uart_tx_reg   <= 1'b1;
                    end else begin
                        uart_bit_reg   <= uart_bit_reg + 4'd1;
                        uart_shift_reg <= {1'b1, uart_shift_reg[9:1]};
                        uart_tx_reg    <= uart_shift_reg[1];
                    end
                end else begin
                    uart_div_reg <= uart_div_reg + DW'(1);
                end
            end else if (wr_en && wr_uart) begin
                uart_busy_reg  <= 1'b1;
                uart_shift_reg <= {1'b1, wr_data[7:0], 1'b0};
                uart_tx_reg    <= 1'b0;
                uart_bit_reg   <= '0;
                uart_div_reg   <= '0;
            end
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign leds     = leds_reg;
    assign uart_tx  = uart_tx_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_mem_bus.sv
// Self-checking bench for mem_bus: directed vector table, hand-written corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_mem_bus;
    localparam int RAM_WORDS = 256;
    localparam int UART_DIV  = 4;
    localparam int FRAME     = 10 * UART_DIV;

    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en;
    logic [15:0] rd_addr, wr_addr;
    logic [31:0] wr_data, rd_data;
    logic        rd_valid, uart_tx, err;
    logic [7:0]  leds;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_bus #(.RAM_WORDS(RAM_WORDS), .UART_DIV(UART_DIV)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .leds(leds), .uart_tx(uart_tx), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [7:0]  exp_leds;
    } vec_t;
    vec_t vecs[15];

    // Behavioural model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_leds;
    logic        m_err;
    int          m_rel;
    int          m_fs;
    logic [7:0]  m_fd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // Holds rd_en like the core: until rd_valid is sampled, then drops it.
    task automatic do_read(input logic [15:0] a, output logic [31:0] d, output int lat);
        lat = -1; d = '0;
        rd_addr = a; rd_en = 1'b1;
        for (int k = 0; k < 8 && lat < 0; k++) begin
            if (rd_valid) begin
                lat = k; d = rd_data;
            end else begin
                tick();
            end
        end
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    function automatic logic exp_tx(input int t, input logic [7:0] d);
        int b;
        if (t < 0 || t >= FRAME) return 1'b1;
        b = t / UART_DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic logic m_busy(input int t);
        return (t >= m_fs) && (t < m_fs + FRAME);
    endfunction

    function automatic logic is_ram(input logic [15:0] a);
        return (a & 16'hFFFC) < 16'(RAM_WORDS * 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a, input int t);
        logic [15:0] w;
        w = a & 16'hFFFC;
        if (is_ram(a))      return m_ram[int'(w >> 2)];
        if (w == 16'hF000)  return {24'b0, m_leds};
        if (w == 16'hF004)  return {31'b0, m_busy(t)};
        if (w == 16'hF008)  return 32'(t - m_rel);
        return 32'b0;
    endfunction

    function automatic logic rd_bad(input logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFC;
        return (a[1:0] != 2'b00) ||
               !(is_ram(a) || w == 16'hF000 || w == 16'hF004 || w == 16'hF008);
    endfunction

    function automatic logic wr_bad(input logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFC;
        return (a[1:0] != 2'b00) || !(is_ram(a) || w == 16'hF000 || w == 16'hF004);
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7: a = 16'($urandom_range(0, 15)) << 2;
            8, 9:   a = 16'((RAM_WORDS - 1) * 4);
            10, 11, 12: a = 16'hF000;
            13, 14: a = 16'hF004;
            15, 16, 17: a = 16'hF008;
            18:     a = 16'(RAM_WORDS * 4);
            default: a = 16'($urandom_range(16'hF00C, 16'hFFFC)) & 16'hFFFC;
        endcase
        if ($urandom_range(0, 39) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int lat, pulses, t;
        logic e_valid, r;
        int pend_cyc, gap_from;
        logic can_acc;
        logic [31:0] pend_data;
        logic core_req, core_cool;
        int core_linger;

        rd_addr = '0; wr_addr = '0; wr_data = '0;
        do_reset();

        // ---------------- directed vector table ----------------
        vecs[0]  = '{1'b1, 16'h0010, 32'h12345678, 32'h0,        1'b0, 8'h00};
        vecs[1]  = '{1'b0, 16'h0010, 32'h0,        32'h12345678, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 16'hF000, 32'h000001A5, 32'h0,        1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 16'hF000, 32'h0,        32'h000000A5, 1'b0, 8'hA5};
        vecs[4]  = '{1'b1, 16'h03FC, 32'hDEADBEEF, 32'h0,        1'b0, 8'hA5};
        vecs[5]  = '{1'b0, 16'h03FC, 32'h0,        32'hDEADBEEF, 1'b0, 8'hA5};
        vecs[6]  = '{1'b0, 16'hF004, 32'h0,        32'h0,        1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 16'h0400, 32'h0,        32'h0,        1'b1, 8'hA5};
        vecs[8]  = '{1'b0, 16'h8000, 32'h0,        32'h0,        1'b1, 8'hA5};
        vecs[9]  = '{1'b1, 16'h0012, 32'hCAFEF00D, 32'h0,        1'b1, 8'hA5};
        vecs[10] = '{1'b0, 16'h0010, 32'h0,        32'hCAFEF00D, 1'b1, 8'hA5};
        vecs[11] = '{1'b1, 16'hF008, 32'h00000005, 32'h0,        1'b1, 8'hA5};
        vecs[12] = '{1'b0, 16'h0013, 32'h0,        32'hCAFEF00D, 1'b1, 8'hA5};
        vecs[13] = '{1'b1, 16'hF001, 32'h0000005A, 32'h0,        1'b1, 8'h5A};
        vecs[14] = '{1'b0, 16'hF000, 32'h0,        32'h0000005A, 1'b1, 8'h5A};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata);
                $display("vec %0d write addr=0x%04h data=0x%08h err=%0b leds=0x%02h",
                         i, vecs[i].addr, vecs[i].wdata, err, leds);
            end else begin
                do_read(vecs[i].addr, d, lat);
                check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
                $display("vec %0d read  addr=0x%04h data=0x%08h err=%0b latency=%0d",
                         i, vecs[i].addr, d, err, lat);
            end
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
        end

        // ---------------- reset values, misaligned write after reset ----------------
        do_reset();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        do_write(16'h0012, 32'h0BADF00D);
        check("misalign_wr_err", 32'(err), 32'd1);
        do_read(16'h0010, d, lat);
        check("misalign_wr_data", d, 32'h0BADF00D);
        $display("seq misaligned write 0x0012 -> word4=0x%08h err=%0b", d, err);

        do_reset();
        do_write(16'hF008, 32'h1);
        check("cnt_wr_err", 32'(err), 32'd1);
        $display("seq write to counter err=%0b", err);

        // ---------------- counter read 20 cycles after reset release ----------------
        do_reset();
        repeat (20) tick();
        do_read(16'hF008, d, lat);
        check("cnt_read", d, 32'd20);
        check("cnt_err", 32'(err), 32'd0);
        $display("seq counter read -> %0d", d);

        // ---------------- held request ----------------
        rd_addr = 16'h0010; rd_en = 1'b1; pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (rd_valid) pulses++;
            tick();
        end
        check("held_pulses", 32'(pulses), 32'd1);
        rd_en = 1'b0;
        tick();
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rearm_valid_k%0d", k), 32'(rd_valid), 32'(k == 2));
            tick();
        end
        rd_en = 1'b0;
        tick();
        $display("seq held request pulses=%0d", pulses);

        // ---------------- UART frame, dropped second write, busy status ----------------
        do_reset();
        do_write(16'hF004, 32'h155);
        for (int k = 1; k <= 60; k++) begin
            wr_en = (k == 10); wr_addr = 16'hF004; wr_data = 32'hAA;
            rd_addr = 16'hF004; rd_en = (k >= 15 && k <= 17);
            check($sformatf("uart_tx_k%0d", k), 32'(uart_tx), 32'(exp_tx(k - 1, 8'h55)));
            if (k == 17) begin
                check("uart_busy_valid", 32'(rd_valid), 32'd1);
                check("uart_busy_data", rd_data, 32'd1);
            end
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        do_read(16'hF004, d, lat);
        check("uart_idle_status", d, 32'd0);
        check("uart_err", 32'(err), 32'd0);
        $display("seq uart frame 0x55 done status=%0d err=%0b", d, err);

        // ---------------- reset mid-read and mid-frame ----------------
        do_write(16'hF000, 32'h3C);
        do_write(16'hF004, 32'h00);
        repeat (3) tick();
        check("mid_tx_busy", 32'(uart_tx), 32'd0);
        rd_addr = 16'h0010; rd_en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_rdata", rd_data, 32'd0);
        check("mid_tx", 32'(uart_tx), 32'd1);
        check("mid_leds", 32'(leds), 32'd0);
        do_read(16'hF008, d, lat);
        check("mid_cnt", d, 32'd0);
        for (int k = 0; k < 6; k++) begin
            check("mid_tx_idle", 32'(uart_tx), 32'd1);
            tick();
        end
        $display("seq reset mid-read/mid-frame counter=%0d", d);

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_rel = cyc; m_leds = '0; m_err = 1'b0; m_fs = -100000; m_fd = '0;
        for (int w = 0; w < 17; w++) begin
            int idx;
            idx = (w < 16) ? w : RAM_WORDS - 1;
            d = $urandom;
            m_ram[idx] = d;
            do_write(16'(idx * 4), d);
        end
        can_acc = 1'b1; pend_cyc = -1; pend_data = '0; gap_from = 0;
        core_req = 1'b0; core_cool = 1'b0; core_linger = 0;

        for (int n = 0; n < 3000; n++) begin
            t = cyc;
            e_valid = (pend_cyc == t);
            check("rnd_valid", 32'(rd_valid), 32'(e_valid));
            check("rnd_rdata", rd_data, e_valid ? pend_data : 32'd0);
            check("rnd_tx", 32'(uart_tx), 32'(exp_tx(t - m_fs, m_fd)));
            check("rnd_leds", 32'(leds), 32'(m_leds));
            check("rnd_err", 32'(err), 32'(m_err));

            r = ($urandom_range(0, 199) == 0);
            rst = r;
            if (core_req) begin
                rd_en = 1'b1;
                if (e_valid) begin
                    core_req = 1'b0;
                    core_linger = $urandom_range(0, 2);
                    core_cool = 1'b1;
                end
            end else if (core_linger > 0) begin
                rd_en = 1'b1;
                core_linger--;
            end else if (core_cool) begin
                rd_en = 1'b0;
                core_cool = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                core_req = 1'b1;
                rd_addr = rand_addr();
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
                rd_addr = rand_addr();
            end
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = rand_addr();
            wr_data = $urandom;

            if (r) begin
                m_leds = '0; m_err = 1'b0; m_fs = -100000; m_rel = t + 1;
                can_acc = 1'b1; pend_cyc = -1;
            end else begin
                if (can_acc && rd_en) begin
                    pend_cyc = t + 2;
                    pend_data = model_read(rd_addr, t);
                    if (rd_bad(rd_addr)) m_err = 1'b1;
                    can_acc = 1'b0;
                    gap_from = t + 3;
                end else if (!can_acc && t >= gap_from && !rd_en) begin
                    can_acc = 1'b1;
                end
                if (wr_en) begin
                    if (wr_bad(wr_addr)) m_err = 1'b1;
                    if (is_ram(wr_addr)) m_ram[int'((wr_addr & 16'hFFFC) >> 2)] = wr_data;
                    if ((wr_addr & 16'hFFFC) == 16'hF000) m_leds = wr_data[7:0];
                    if ((wr_addr & 16'hFFFC) == 16'hF004 && !m_busy(t)) begin
                        m_fs = t + 1;
                        m_fd = wr_data[7:0];
                    end
                end
            end
            tick();
        end
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        $display("seq random run of 3000 cycles complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
